coef_bank: RTL and testbench
============================

// Module: coef_bank
// PURPOSE
//  Double-buffered parameter RAM directly downstream of memif. memif writes/reads the
//  shadow bank over SPI; the DSP datapath reads the active bank. A host commit swaps
//  banks atomically at the next audio frame_sync, then a copy engine refreshes the new
//  shadow from the new active bank so later partial host edits build on live values.
// PARAMETERS
//  WORD_WIDTH  8  data word width (matches memif WORD_WIDTH)
//  ADDR_WIDTH  2  address width; NUM_ADDRS = 1<<ADDR_WIDTH words per bank
// PORTS
//  clk            in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  wr_addr        in   ADDR_WIDTH  host (memif) write address, shadow bank
//  wr_data        in   WORD_WIDTH  host write data
//  wr_enable      in   1           host write strobe, one word per cycle
//  rd_addr        in   ADDR_WIDTH  host read address, shadow bank
//  rd_data        out  WORD_WIDTH  host read data, registered, 1-cycle latency
//  dsp_addr       in   ADDR_WIDTH  DSP read address, active bank
//  dsp_data       out  WORD_WIDTH  DSP read data, registered, 1-cycle latency
//  frame_sync     in   1           one-cycle pulse at audio frame boundary
//  commit_req     in   1           one-cycle pulse: request bank swap
//  commit_pending out  1           swap requested, not yet performed
//  copy_busy      out  1           copy engine running
//  active_bank    out  1           index of bank the DSP reads
// BEHAVIOUR
//  - Storage: mem[2][NUM_ADDRS], initialised to 0 at configuration. reset does NOT
//    clear contents. shadow = ~active_bank.
//  - Reset: rd_data=0, dsp_data=0, commit_pending=0, copy_busy=0, active_bank=0,
//    dirty[]=0, copy_addr=0. Reset mid-copy aborts copy; partial copy contents stay.
//  - Reads: rd_data <= mem[shadow][rd_addr]; dsp_data <= mem[active][dsp_addr]; both
//    every cycle; read reflects writes from earlier cycles only (no bypass).
//  - Host write: wr_enable -> mem[shadow][wr_addr] <= wr_data; dirty[wr_addr] <= 1.
//  - commit_req sets commit_pending next cycle; repeated requests merge (still one swap).
//  - Swap cycle: frame_sync & commit_pending & ~copy_busy. Next cycle: active_bank
//    toggles, commit_pending=0, copy_busy=1, copy_addr=0, dirty[]=0.
//    commit_req coincident with frame_sync: pending not yet set -> no swap that frame.
//    commit_req coincident with swap cycle: pending stays set (a second swap queued).
//    wr_enable in swap cycle: writes the pre-swap shadow (becoming active), no dirty set;
//    the copy then propagates it.
//  - States: IDLE (copy_busy=0) / COPY (copy_busy=1).
//    COPY, per cycle: if wr_enable: host write only, copy stalls (copy_addr holds).
//    else: if !dirty[copy_addr] mem[shadow][copy_addr] <= mem[active][copy_addr];
//    copy_addr++. After copy_addr NUM_ADDRS-1 is handled -> IDLE next cycle.
//    copy_busy high exactly NUM_ADDRS + (stall cycles) cycles.
//  - Dirty addresses (host-written since swap) are never overwritten by the copy.
//  - frame_sync while copy_busy with pending: swap deferred to first frame_sync
//    after copy_busy falls. Swap never changes active mid-frame.
//  - copy_addr wraps naturally at NUM_ADDRS; no other arithmetic.
// TESTING (WORD_WIDTH=8, ADDR_WIDTH=2)
//  1 reset 2 cycles -> active_bank=0, copy_busy=0, commit_pending=0, rd_data=dsp_data=0.
//  2 write 8'h11@1; rd_addr=1 -> rd_data=11 next cycle; dsp_addr=1 -> dsp_data=00.
//  3 commit_req, frame_sync 3 cycles later -> active_bank=1, dsp_data@1=11; copy_busy
//    high exactly 4 cycles; afterwards rd_data@1=11 (copied to new shadow).
//  4 write 8'h22@3 in first copy cycle -> copy_busy 5 cycles; shadow@3=22, active@3
//    unchanged (dirty skip); shadow@0..2 equal active.
//  5 commit_req + frame_sync during copy -> no toggle; toggle at next frame_sync
//    after copy_busy falls; commit_pending clears then.
//  6 reset mid-copy -> next cycle copy_busy=0, active_bank=0, commit_pending=0.

Source files
------------

// File: rtl/coef_bank.sv
// Double-buffered coefficient RAM: the host edits the shadow bank and the DSP reads the active bank.
// A commit swaps the banks at a frame boundary, then a copy engine refreshes the new shadow bank.
//
// state | meaning
// IDLE  | no copy running; a pending commit swaps banks on frame_sync
// COPY  | refreshing the shadow bank from the active bank, one word per free cycle
module coef_bank #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] dsp_addr,
  output logic [WORD_WIDTH-1:0] dsp_data,
  input  logic                  frame_sync,
  input  logic                  commit_req,
  output logic                  commit_pending,
  output logic                  copy_busy,
  output logic                  active_bank
);

  localparam int NUM_ADDRS = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, COPY} state_t;

  state_t                  state_q, state_d;
  logic                    active_q, active_d;
  logic                    pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]   copy_addr_q, copy_addr_d;
  logic [NUM_ADDRS-1:0]    dirty_q, dirty_d;
  logic [WORD_WIDTH-1:0]   rd_data_q, dsp_data_q;
  logic                    swap;
  logic                    copy_we;
  logic                    shadow;

  // Contents come up zeroed at configuration and survive reset.
  logic [WORD_WIDTH-1:0]   mem_q [2][NUM_ADDRS] = '{default: '0};

  assign shadow = ~active_q;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q | commit_req;
    copy_addr_d = copy_addr_q;
    dirty_d     = dirty_q;
    copy_we     = 1'b0;
    swap        = frame_sync & pending_q & (state_q == IDLE);

    if (wr_enable && !swap) begin
      dirty_d[wr_addr] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (swap) begin
          state_d     = COPY;
          active_d    = ~active_q;
          pending_d   = commit_req;
          copy_addr_d = '0;
          dirty_d     = '0;
        end
      end
      COPY: begin
        // A host write owns the shadow port this cycle, so the copy stalls.
        if (!wr_enable) begin
          copy_we     = ~dirty_q[copy_addr_q];
          copy_addr_d = copy_addr_q + 1'b1;
          if (copy_addr_q == '1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      copy_addr_q <= '0;
      dirty_q     <= '0;
      rd_data_q   <= '0;
      dsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      copy_addr_q <= copy_addr_d;
      dirty_q     <= dirty_d;
      rd_data_q   <= mem_q[shadow][rd_addr];
      dsp_data_q  <= mem_q[active_q][dsp_addr];
    end
  end

  // In the swap cycle shadow still names the bank about to go live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_enable) begin
        mem_q[shadow][wr_addr] <= wr_data;
      end else if (copy_we) begin
        mem_q[shadow][copy_addr_q] <= mem_q[active_q][copy_addr_q];
      end
    end
  end

  assign rd_data        = rd_data_q;
  assign dsp_data       = dsp_data_q;
  assign commit_pending = pending_q;
  assign copy_busy      = (state_q == COPY);
  assign active_bank    = active_q;

endmodule

// File: tb/tb_coef_bank.sv
// Bench for coef_bank: directed scenarios followed by random traffic, all checked
// against a behavioural model of the two banks, the pending commit and the copy progress.
module tb_coef_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_enable = 1'b0;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [1:0] dsp_addr = '0;
  logic [7:0] dsp_data;
  logic       frame_sync = 1'b0;
  logic       commit_req = 1'b0;
  logic       commit_pending;
  logic       copy_busy;
  logic       active_bank;

  int passed = 0;
  int total  = 0;

  // Model: copy_idx counts words already copied; 4 means no copy running.
  logic [7:0] m_mem [2][4];
  int         m_active;
  int         m_pending;
  int         m_copy_idx;
  bit [3:0]   m_dirty;
  logic [7:0] m_rd;
  logic [7:0] m_dsp;

  coef_bank #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .dsp_addr(dsp_addr), .dsp_data(dsp_data),
    .frame_sync(frame_sync), .commit_req(commit_req),
    .commit_pending(commit_pending), .copy_busy(copy_busy), .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [7:0] old [2][4];
    int  sh;
    bit  busy;
    bit  swap;
    if (reset) begin
      m_rd = 8'h00; m_dsp = 8'h00; m_pending = 0;
      m_copy_idx = 4; m_active = 0; m_dirty = '0;
    end else begin
      old  = m_mem;
      sh   = 1 - m_active;
      busy = (m_copy_idx < 4);
      swap = frame_sync && (m_pending != 0) && !busy;
      m_rd  = old[sh][rd_addr];
      m_dsp = old[m_active][dsp_addr];
      if (wr_enable) begin
        m_mem[sh][wr_addr] = wr_data;
        if (!swap) m_dirty[wr_addr] = 1'b1;
      end else if (busy) begin
        if (!m_dirty[m_copy_idx]) m_mem[sh][m_copy_idx] = old[m_active][m_copy_idx];
        m_copy_idx++;
      end
      if (swap) begin
        m_active = sh; m_pending = commit_req ? 1 : 0; m_copy_idx = 0; m_dirty = '0;
      end else if (commit_req) begin
        m_pending = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("dsp_data", dsp_data, m_dsp);
    chk("commit_pending", {7'b0, commit_pending}, 8'(m_pending));
    chk("copy_busy", {7'b0, copy_busy}, {7'b0, m_copy_idx < 4});
    chk("active_bank", {7'b0, active_bank}, 8'(m_active));
  endtask

  initial begin
    int n;
    int g;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4; a++) m_mem[b][a] = 8'h00;
    m_active = 0; m_pending = 0; m_copy_idx = 4; m_dirty = '0; m_rd = 0; m_dsp = 0;

    // 1: reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("s1_active", {7'b0, active_bank}, 8'h00);
    chk("s1_busy", {7'b0, copy_busy}, 8'h00);
    chk("s1_pending", {7'b0, commit_pending}, 8'h00);
    chk("s1_rd", rd_data, 8'h00);
    chk("s1_dsp", dsp_data, 8'h00);

    // 2: shadow write is visible to the host only
    wr_enable = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
    tick();
    wr_enable = 1'b0; rd_addr = 2'd1; dsp_addr = 2'd1;
    tick();
    chk("s2_rd", rd_data, 8'h11);
    chk("s2_dsp", dsp_data, 8'h00);

    // 3: commit, swap three cycles later, four-cycle copy
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    tick(); tick();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    chk("s3_active", {7'b0, active_bank}, 8'h01);
    n = copy_busy ? 1 : 0; g = 0;
    while (copy_busy && g < 20) begin tick(); g++; if (copy_busy) n++; end
    chk("s3_busy_cycles", 8'(n), 8'd4);
    tick();
    chk("s3_dsp1", dsp_data, 8'h11);
    chk("s3_rd1", rd_data, 8'h11);

    // 4: host write in first copy cycle stalls the copy and is not overwritten
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    n = copy_busy ? 1 : 0;
    wr_enable = 1'b1; wr_addr = 2'd3; wr_data = 8'h22;
    tick();
    wr_enable = 1'b0;
    if (copy_busy) n++;
    g = 0;
    while (copy_busy && g < 20) begin tick(); g++; if (copy_busy) n++; end
    chk("s4_busy_cycles", 8'(n), 8'd5);
    rd_addr = 2'd3; dsp_addr = 2'd3;
    tick();
    chk("s4_shadow3", rd_data, 8'h22);
    chk("s4_active3", dsp_data, 8'h00);
    for (int a = 0; a < 3; a++) begin
      rd_addr = 2'(a); dsp_addr = 2'(a);
      tick();
      chk("s4_shadow_eq_model", rd_data, m_mem[1 - m_active][a]);
      chk("s4_active_eq_model", dsp_data, m_mem[m_active][a]);
    end

    // 5: commit + frame_sync during a copy defer the swap
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    commit_req = 1'b1; frame_sync = 1'b1; tick();
    commit_req = 1'b0; frame_sync = 1'b0;
    chk("s5_no_toggle", {7'b0, active_bank}, 8'h01);
    g = 0;
    while (copy_busy && g < 20) begin tick(); g++; end
    chk("s5_busy_fell", {7'b0, copy_busy}, 8'h00);
    chk("s5_pending_held", {7'b0, commit_pending}, 8'h01);
    chk("s5_still_active", {7'b0, active_bank}, 8'h01);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    chk("s5_toggle", {7'b0, active_bank}, 8'h00);
    chk("s5_pending_clr", {7'b0, commit_pending}, 8'h00);
    g = 0;
    while (copy_busy && g < 20) begin tick(); g++; end

    // 6: reset in the middle of a copy
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s6_busy", {7'b0, copy_busy}, 8'h00);
    chk("s6_active", {7'b0, active_bank}, 8'h00);
    chk("s6_pending", {7'b0, commit_pending}, 8'h00);

    // commit coincident with frame_sync does not swap that frame
    commit_req = 1'b1; frame_sync = 1'b1; tick();
    commit_req = 1'b0; frame_sync = 1'b0;
    chk("cf_no_swap", {7'b0, active_bank}, 8'h00);
    chk("cf_pending", {7'b0, commit_pending}, 8'h01);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    chk("cf_swap", {7'b0, active_bank}, 8'h01);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      wr_enable  = ($urandom_range(0, 2) == 0);
      wr_addr    = 2'($urandom_range(0, 3));
      wr_data    = 8'($urandom);
      rd_addr    = 2'($urandom_range(0, 3));
      dsp_addr   = 2'($urandom_range(0, 3));
      frame_sync = ($urandom_range(0, 4) == 0);
      commit_req = ($urandom_range(0, 6) == 0);
      tick();
    end
    reset = 1'b0; wr_enable = 1'b0; frame_sync = 1'b0; commit_req = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
